pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
Fetch-side PC register and redirect controller. It sits directly downstream of BranchControl and consumes its Diverge output together with the execute-stage opcode and targets. It holds and advances the fetch PC, and redirects it on taken branches, JAL and JALR. It squashes wrong-path instructions in IF/ID for a fixed number of cycles after each redirect, and supplies PC+4 for link writeback.

Parameters:
RESET_PC, 32'h0000_2000, fetch address loaded on reset.
FLUSH_CYCLES, 2, number of cycles KillIF/KillID stay asserted per redirect (legal range 1-7).

Ports:
Clock  in  1  system clock, all state updates on the rising edge
Reset  in  1  synchronous, active-low reset (0 = reset asserted)
Stall  in  1  hazard or imem stall; holds the PC
ExValid  in  1  execute-stage instruction is valid (not a bubble)
ExOpcode  in  7  execute-stage opcode (OPC_BRANCH / OPC_JAL / OPC_JALR compared)
Diverge  in  1  branch-taken decision from BranchControl
BranchTarget  in  32  EX-computed PC+imm, used for branches and JAL
JalrTarget  in  32  ALU rs1+imm, used for JALR
PC  out  32  current fetch address
PCPlus4  out  32  PC+4, modulo 2^32
FetchValid  out  1  PC is a real fetch this cycle
Redirect  out  1  redirect taken this cycle
KillIF  out  1  squash the instruction in IF
KillID  out  1  squash the instruction in ID
Misaligned  out  1  redirect target had bit[1] set

Behaviour:
- States: BOOT, RUN, FLUSH. All outputs are registered except Redirect, KillIF/KillID during the redirect cycle, Misaligned and PCPlus4.
- Reset (Reset==0 at an edge):
  - PC=RESET_PC, state=BOOT, flush counter=0, FetchValid=0.
  - Redirect/Kill*/Misaligned are forced to 0 while Reset==0.
  - Reset overrides everything, including an in-progress flush.
- BOOT: lasts exactly one cycle, FetchValid=0, PC is held. Next state is RUN with FetchValid=1.
- Redirect condition (combinational): take = ExValid & ((ExOpcode==OPC_BRANCH & Diverge) | ExOpcode==OPC_JAL | ExOpcode==OPC_JALR). Diverge is ignored for any other opcode.
- Target selection:
  - JALR uses {JalrTarget[31:1],1'b0}.
  - Branch and JAL use BranchTarget.
  - The loaded PC has bits[1:0] forced to 00.
  - Misaligned = take & selected_target[1].
- Redirect cycle: Redirect=KillIF=KillID=1 in the same cycle.
  - The PC loads the target at the next edge, regardless of Stall (redirect has priority over Stall).
  - Flush counter loads FLUSH_CYCLES-1. State moves to FLUSH if FLUSH_CYCLES>1, otherwise RUN.
- FLUSH: KillIF=KillID=1 and FetchValid=1.
  - The PC advances normally.
  - The counter decrements only when Stall==0; FLUSH exits to RUN at the edge where the counter goes 1->0.
  - A new redirect during FLUSH restarts the counter at FLUSH_CYCLES-1 and loads the new target.
- RUN, no redirect: if Stall==1 the PC holds, otherwise PC <= PC+4.
- Wrap-around: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Simultaneous events:
  - A redirect during BOOT is ignored, because ExValid cannot legally be 1 then; the bench checks that the PC does not change.
  - Stall together with a redirect: the redirect wins, and the Stall is honoured from the following cycle.

Optional Feature:
BRANCH_PERF_EN.
- Defined: adds outputs BranchCount[31:0] and TakenCount[31:0].
  - BranchCount increments on every cycle with ExValid & ExOpcode==OPC_BRANCH & ~Stall.
  - TakenCount increments when Diverge is also 1.
  - Both counters clear on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset: Reset=0 for 2 cycles, then release -> PC=32'h2000, FetchValid=0 for one cycle, then 1; PC reads 2000, 2004, 2008 on successive cycles.
2. Taken BEQ: ExOpcode=OPC_BRANCH, Diverge=1, BranchTarget=32'h2100 -> Redirect=Kill*=1 that cycle; PC=2100 next cycle; Kill* high for 2 cycles total, then 0 and PC=2104.
3. Untaken branch plus stall: OPC_BRANCH with Diverge=0 -> no Redirect; Stall=1 for 3 cycles -> PC holds at its value, then resumes +4.
4. JALR: JalrTarget=32'h0000_3007 -> PC=32'h3004, Misaligned=1 for one cycle; redirect taken with Stall=1 asserted.
5. Back-to-back: a JAL to 32'h4000 during the FLUSH of a prior redirect -> counter restarts, Kill* stays high 2 more cycles, PC=4000; then a reset mid-flush -> PC=2000 and Kill*=0.
6. Wrap and perf: PC at FFFF_FFFC advances to 0; with BRANCH_PERF_EN, 5 branches with 3 taken -> BranchCount=5, TakenCount=3.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/JAL/JALR redirect and fixed-length IF/ID squash window.
// Optional branch statistics counters are enabled by defining BRANCH_PERF_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_2000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        ExValid,
    input  logic [6:0]  ExOpcode,
    input  logic        Diverge,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JalrTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Redirect,
    output logic        KillIF,
    output logic        KillID,
    output logic        Misaligned
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] TakenCount
`endif
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        fetch_valid_q, fetch_valid_d;

    logic        is_branch, is_jal, is_jalr, take;
    logic [31:0] sel_target;
    logic        unused_bits;

    // A redirect is never taken in BOOT or while reset is held.
    always_comb begin
        is_branch  = (ExOpcode == OPC_BRANCH);
        is_jal     = (ExOpcode == OPC_JAL);
        is_jalr    = (ExOpcode == OPC_JALR);
        take       = Reset && (state_q != ST_BOOT) && ExValid &&
                     ((is_branch && Diverge) || is_jal || is_jalr);
        sel_target = is_jalr ? {JalrTarget[31:1], 1'b0} : BranchTarget;
    end

    assign unused_bits = ^{JalrTarget[0], sel_target[0]};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        fetch_valid_d = 1'b1;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (take) begin
            pc_d    = {sel_target[31:2], 2'b00};
            cnt_d   = FLUSH_LOAD;
            state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (!Stall) begin
            pc_d = pc_q + 32'd4;
            if (state_q == ST_FLUSH) begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            cnt_q         <= 3'd0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Kill is combinational in the redirect cycle and registered through FLUSH.
    always_comb begin
        PC         = pc_q;
        PCPlus4    = pc_q + 32'd4;
        FetchValid = fetch_valid_q;
        Redirect   = take;
        KillIF     = take || (Reset && (state_q == ST_FLUSH));
        KillID     = take || (Reset && (state_q == ST_FLUSH));
        Misaligned = take && sel_target[1];
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] taken_count_q, taken_count_d;
    logic        count_branch;

    always_comb begin
        count_branch   = ExValid && is_branch && !Stall;
        branch_count_d = branch_count_q + {31'd0, count_branch};
        taken_count_d  = taken_count_q + {31'd0, count_branch && Diverge};
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            branch_count_q <= 32'd0;
            taken_count_q  <= 32'd0;
        end else begin
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign BranchCount = branch_count_q;
    assign TakenCount  = taken_count_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the fetch PC.
module tb_pc_redirect_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_2000;
    localparam int          FLUSH_N = 2;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_ADD  = 7'b0110011;

    logic        Clock = 1'b0;
    logic        Reset, Stall, ExValid, Diverge;
    logic [6:0]  ExOpcode;
    logic [31:0] BranchTarget, JalrTarget;
    logic [31:0] PC, PCPlus4;
    logic        FetchValid, Redirect, KillIF, KillID, Misaligned;
`ifdef BRANCH_PERF_EN
    logic [31:0] BranchCount, TakenCount;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state (m_*), staged next state (n_*), expected outputs this cycle (e_*).
    logic [31:0] m_pc = 32'd0, n_pc;
    bit          m_known = 0, n_known;
    bit          m_boot = 1, n_boot;
    bit          m_fv = 0, n_fv;
    int          m_left = 0, n_left;
    logic [31:0] m_bc = 32'd0, n_bc, m_tc = 32'd0, n_tc;
    logic [31:0] e_pc, e_pc4, e_bc, e_tc;
    logic        e_fv, e_redir, e_kill, e_mis;

    pc_redirect_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .ExValid(ExValid),
        .ExOpcode(ExOpcode), .Diverge(Diverge), .BranchTarget(BranchTarget),
        .JalrTarget(JalrTarget), .PC(PC), .PCPlus4(PCPlus4), .FetchValid(FetchValid),
        .Redirect(Redirect), .KillIF(KillIF), .KillID(KillID), .Misaligned(Misaligned)
`ifdef BRANCH_PERF_EN
        , .BranchCount(BranchCount), .TakenCount(TakenCount)
`endif
    );

    always #5 Clock = ~Clock;

    // Applies one cycle of inputs after the falling edge and predicts outputs and next state.
    task automatic drive(input logic rst, input logic stl, input logic ev, input logic [6:0] op,
                         input logic dv, input logic [31:0] bt, input logic [31:0] jt);
        logic        take;
        logic [31:0] tgt;
        @(negedge Clock);
        Reset = rst; Stall = stl; ExValid = ev; ExOpcode = op;
        Diverge = dv; BranchTarget = bt; JalrTarget = jt;
        take = rst && !m_boot && ev && ((op == OP_BR && dv) || op == OP_JAL || op == OP_JALR);
        tgt  = (op == OP_JALR) ? (jt & 32'hFFFF_FFFE) : bt;
        e_redir = take;
        e_kill  = rst && (take || m_left > 0);
        e_mis   = take && tgt[1];
        e_pc    = m_pc;
        e_pc4   = m_pc + 32'd4;
        e_fv    = m_fv;
        e_bc    = m_bc;
        e_tc    = m_tc;
        n_pc = m_pc; n_known = m_known; n_boot = m_boot; n_fv = m_fv;
        n_left = m_left; n_bc = m_bc; n_tc = m_tc;
        if (!rst) begin
            n_pc = RST_PC; n_known = 1; n_boot = 1; n_fv = 0; n_left = 0; n_bc = 0; n_tc = 0;
        end else begin
            n_fv = 1;
            if (ev && op == OP_BR && !stl) begin
                n_bc = m_bc + 32'd1;
                if (dv) n_tc = m_tc + 32'd1;
            end
            if (m_boot) begin
                n_boot = 0;
            end else if (take) begin
                n_pc   = tgt & 32'hFFFF_FFFC;
                n_left = FLUSH_N - 1;
            end else if (!stl) begin
                n_pc = m_pc + 32'd4;
                if (m_left > 0) n_left = m_left - 1;
            end
        end
        #1;
    endtask

    task automatic tick();
        @(posedge Clock);
        m_pc = n_pc; m_known = n_known; m_boot = n_boot; m_fv = n_fv;
        m_left = n_left; m_bc = n_bc; m_tc = n_tc;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        tick();
        drive(0, 0, 1, OP_JAL, 0, 32'h5000, 32'd0);
        n_compared++;
        if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL reset_redirect: got %b want %b", Redirect, e_redir); end
        n_compared++;
        if (KillIF !== e_kill) begin n_mismatched++; $display("[TB] FAIL reset_killif: got %b want %b", KillIF, e_kill); end
        n_compared++;
        if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %h want %h", PC, e_pc); end
        tick();
        drive(1, 0, 1, OP_JAL, 0, 32'h5000, 32'd0);
        n_compared++;
        if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL boot_pc: got %h want %h", PC, e_pc); end
        n_compared++;
        if (FetchValid !== e_fv) begin n_mismatched++; $display("[TB] FAIL boot_fetchvalid: got %b want %b", FetchValid, e_fv); end
        n_compared++;
        if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL boot_redirect: got %b want %b", Redirect, e_redir); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
            n_compared++;
            if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL run_pc[%0d]: got %h want %h", i, PC, e_pc); end
            n_compared++;
            if (FetchValid !== e_fv) begin n_mismatched++; $display("[TB] FAIL run_fetchvalid[%0d]: got %b want %b", i, FetchValid, e_fv); end
            tick();
        end
    endtask

    task automatic test_taken_branch();
        drive(1, 0, 1, OP_BR, 1, 32'h2100, 32'd0);
        n_compared++;
        if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL beq_redirect: got %b want %b", Redirect, e_redir); end
        n_compared++;
        if ({KillIF, KillID} !== {e_kill, e_kill}) begin n_mismatched++; $display("[TB] FAIL beq_kill: got %b%b want %b", KillIF, KillID, e_kill); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
            n_compared++;
            if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL beq_pc[%0d]: got %h want %h", i, PC, e_pc); end
            n_compared++;
            if ({KillIF, KillID} !== {e_kill, e_kill}) begin n_mismatched++; $display("[TB] FAIL beq_flush_kill[%0d]: got %b%b want %b", i, KillIF, KillID, e_kill); end
            tick();
        end
    endtask

    task automatic test_untaken_stall();
        drive(1, 0, 1, OP_BR, 0, 32'h2300, 32'd0);
        n_compared++;
        if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL untaken_redirect: got %b want %b", Redirect, e_redir); end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, (i < 3), 0, OP_ADD, 0, 32'd0, 32'd0);
            n_compared++;
            if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL stall_pc[%0d]: got %h want %h", i, PC, e_pc); end
            tick();
        end
    endtask

    task automatic test_jalr();
        drive(1, 1, 1, OP_JALR, 0, 32'd0, 32'h0000_3007);
        n_compared++;
        if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL jalr_redirect: got %b want %b", Redirect, e_redir); end
        n_compared++;
        if (Misaligned !== e_mis) begin n_mismatched++; $display("[TB] FAIL jalr_misaligned: got %b want %b", Misaligned, e_mis); end
        tick();
        drive(1, 1, 0, OP_ADD, 0, 32'd0, 32'd0);
        n_compared++;
        if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL jalr_pc: got %h want %h", PC, e_pc); end
        n_compared++;
        if (Misaligned !== e_mis) begin n_mismatched++; $display("[TB] FAIL jalr_misaligned_after: got %b want %b", Misaligned, e_mis); end
        n_compared++;
        if (KillIF !== e_kill) begin n_mismatched++; $display("[TB] FAIL jalr_stalled_kill: got %b want %b", KillIF, e_kill); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
            n_compared++;
            if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL jalr_run_pc[%0d]: got %h want %h", i, PC, e_pc); end
            n_compared++;
            if (KillID !== e_kill) begin n_mismatched++; $display("[TB] FAIL jalr_killid[%0d]: got %b want %b", i, KillID, e_kill); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 1, OP_BR, 1, 32'h2100, 32'd0);
        tick();
        drive(1, 0, 1, OP_JAL, 0, 32'h4000, 32'd0);
        n_compared++;
        if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL b2b_redirect: got %b want %b", Redirect, e_redir); end
        n_compared++;
        if (KillIF !== e_kill) begin n_mismatched++; $display("[TB] FAIL b2b_kill: got %b want %b", KillIF, e_kill); end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
            n_compared++;
            if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL b2b_pc[%0d]: got %h want %h", i, PC, e_pc); end
            n_compared++;
            if (KillIF !== e_kill) begin n_mismatched++; $display("[TB] FAIL b2b_flush_kill[%0d]: got %b want %b", i, KillIF, e_kill); end
            tick();
        end
        drive(1, 0, 1, OP_JAL, 0, 32'h5000, 32'd0);
        tick();
        drive(0, 0, 1, OP_JAL, 0, 32'h6000, 32'd0);
        n_compared++;
        if ({KillIF, KillID, Redirect} !== {e_kill, e_kill, e_redir}) begin
            n_mismatched++; $display("[TB] FAIL midflush_reset_outputs: got %b%b%b want %b%b%b", KillIF, KillID, Redirect, e_kill, e_kill, e_redir);
        end
        tick();
        drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        n_compared++;
        if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL midflush_reset_pc: got %h want %h", PC, e_pc); end
        n_compared++;
        if (KillIF !== e_kill) begin n_mismatched++; $display("[TB] FAIL midflush_reset_kill: got %b want %b", KillIF, e_kill); end
        tick();
    endtask

    task automatic test_wrap();
        drive(1, 0, 1, OP_JAL, 0, 32'hFFFF_FFFC, 32'd0);
        tick();
        drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        n_compared++;
        if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL wrap_pc_top: got %h want %h", PC, e_pc); end
        n_compared++;
        if (PCPlus4 !== e_pc4) begin n_mismatched++; $display("[TB] FAIL wrap_pcplus4: got %h want %h", PCPlus4, e_pc4); end
        tick();
        drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        n_compared++;
        if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL wrap_pc_zero: got %h want %h", PC, e_pc); end
        tick();
    endtask

`ifdef BRANCH_PERF_EN
    task automatic test_perf();
        logic [4:0] taken_pat;
        taken_pat = 5'b10101;
        drive(0, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        tick();
        drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, OP_BR, taken_pat[i], 32'h2400 + 32'(i * 64), 32'd0);
            tick();
            drive(1, 1, 1, OP_BR, 1, 32'h2800, 32'd0);
            tick();
            drive(1, 0, 1, OP_ADD, 1, 32'h2900, 32'd0);
            tick();
        end
        drive(1, 0, 0, OP_ADD, 0, 32'd0, 32'd0);
        n_compared++;
        if (BranchCount !== e_bc) begin n_mismatched++; $display("[TB] FAIL perf_branchcount: got %0d want %0d", BranchCount, e_bc); end
        n_compared++;
        if (TakenCount !== e_tc) begin n_mismatched++; $display("[TB] FAIL perf_takencount: got %0d want %0d", TakenCount, e_tc); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [6:0] op;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: op = OP_BR;
                1: op = OP_JAL;
                2: op = OP_JALR;
                default: op = 7'($urandom);
            endcase
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  op, 1'($urandom_range(0, 1)), $urandom, $urandom);
            n_compared++;
            if (PC !== e_pc) begin n_mismatched++; $display("[TB] FAIL rnd_pc[%0d]: got %h want %h", i, PC, e_pc); end
            n_compared++;
            if (PCPlus4 !== e_pc4) begin n_mismatched++; $display("[TB] FAIL rnd_pcplus4[%0d]: got %h want %h", i, PCPlus4, e_pc4); end
            n_compared++;
            if (FetchValid !== e_fv) begin n_mismatched++; $display("[TB] FAIL rnd_fetchvalid[%0d]: got %b want %b", i, FetchValid, e_fv); end
            n_compared++;
            if (Redirect !== e_redir) begin n_mismatched++; $display("[TB] FAIL rnd_redirect[%0d]: got %b want %b", i, Redirect, e_redir); end
            n_compared++;
            if ({KillIF, KillID} !== {e_kill, e_kill}) begin n_mismatched++; $display("[TB] FAIL rnd_kill[%0d]: got %b%b want %b", i, KillIF, KillID, e_kill); end
            n_compared++;
            if (Misaligned !== e_mis) begin n_mismatched++; $display("[TB] FAIL rnd_misaligned[%0d]: got %b want %b", i, Misaligned, e_mis); end
`ifdef BRANCH_PERF_EN
            n_compared++;
            if ({BranchCount, TakenCount} !== {e_bc, e_tc}) begin
                n_mismatched++; $display("[TB] FAIL rnd_perf[%0d]: got %0d/%0d want %0d/%0d", i, BranchCount, TakenCount, e_bc, e_tc);
            end
`endif
            tick();
        end
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; ExValid = 1'b0; ExOpcode = OP_ADD;
        Diverge = 1'b0; BranchTarget = 32'd0; JalrTarget = 32'd0;
        test_reset();
        test_taken_branch();
        test_untaken_stall();
        test_jalr();
        test_back_to_back();
        test_wrap();
`ifdef BRANCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
